// File: rtl/clock_ctrl_pkg.sv
// Shared item codes, FSM state type and item sequencing for the clock adjust controller.
package clock_ctrl_pkg;

    localparam logic [2:0] SEL_NONE  = 3'b000;
    localparam logic [2:0] SEL_SEC   = 3'b001;
    localparam logic [2:0] SEL_MIN   = 3'b010;
    localparam logic [2:0] SEL_HOUR  = 3'b011;
    localparam logic [2:0] SEL_DAY   = 3'b100;
    localparam logic [2:0] SEL_MONTH = 3'b110;
    localparam logic [2:0] SEL_YEAR  = 3'b101;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_EDIT = 1'b1
    } state_t;

    // Edit order is sec, min, hour, day, month, year; year wraps back to none.
    function automatic logic [2:0] next_item(input logic [2:0] sel);
        logic [2:0] nxt;
        case (sel)
            SEL_NONE:  nxt = SEL_SEC;
            SEL_SEC:   nxt = SEL_MIN;
            SEL_MIN:   nxt = SEL_HOUR;
            SEL_HOUR:  nxt = SEL_DAY;
            SEL_DAY:   nxt = SEL_MONTH;
            SEL_MONTH: nxt = SEL_YEAR;
            default:   nxt = SEL_NONE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Button rise detector; with AUTO_REPEAT_EN defined it also emits repeat pulses
// after the button has been held HOLD_DLY cycles, one every REP_DIV cycles.
module btn_pulse
    import clock_ctrl_pkg::*;
`ifdef AUTO_REPEAT_EN
#(
    parameter int unsigned HOLD_DLY = 2,
    parameter int unsigned REP_DIV  = 1,
    parameter int unsigned CW       = 6
)
`endif
(
    input  logic clk_1Hz,
    input  logic rst,
    input  logic btn,
`ifdef AUTO_REPEAT_EN
    input  logic clear,
`endif
    output logic pulse
);

    logic btn_q;
    logic rise;

    assign rise = btn & ~btn_q;

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

`ifdef AUTO_REPEAT_EN
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] rep_cnt;
    logic          rep_hit;

    assign rep_hit = btn & (hold_cnt == CW'(HOLD_DLY)) & (rep_cnt == '0);
    assign pulse   = rise | rep_hit;

    // hold_cnt saturates at HOLD_DLY; rep_cnt then paces the repeat pulses.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else if (clear || !btn || rise) begin
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else if (hold_cnt != CW'(HOLD_DLY)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else if (rep_cnt == CW'(REP_DIV - 1)) begin
            rep_cnt  <= '0;
        end else begin
            rep_cnt  <= rep_cnt + 1'b1;
        end
    end
`else
    assign pulse = rise;
`endif

endmodule

// File: rtl/adjust_ctrl.sv
// Time/date adjust controller: walks select_item over the counter chain and issues up/down pulses.
// Optional auto-repeat of held up/down buttons is enabled by defining AUTO_REPEAT_EN.
module adjust_ctrl #(
    parameter int unsigned TIMEOUT  = 30,
    parameter int unsigned HOLD_DLY = 2,
    parameter int unsigned REP_DIV  = 1,
    parameter int unsigned CW       = 6
) (
    input  logic       clk_1Hz,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [2:0] select_item,
    output logic       up,
    output logic       down,
    output logic       en_1,
    output logic       editing
);

    import clock_ctrl_pkg::*;

    if (TIMEOUT < 1 || REP_DIV < 1 || (TIMEOUT >> CW) != 0 || (HOLD_DLY >> CW) != 0) begin : g_cfg_check
        $error("adjust_ctrl: TIMEOUT/HOLD_DLY must be >=1 and fit in CW bits, REP_DIV >= 1");
    end

    state_t        state;
    state_t        state_next;
    logic [2:0]    sel_next;
    logic          up_next;
    logic          down_next;
    logic [CW-1:0] idle_cnt;
    logic [CW-1:0] idle_next;
    logic          mode_q;
    logic          mode_rise;
    logic          up_pulse;
    logic          down_pulse;
    logic          conflict;

    assign mode_rise = btn_mode & ~mode_q;
    assign conflict  = btn_up & btn_down;
    assign en_1      = (state == ST_RUN);
    assign editing   = (state == ST_EDIT);

`ifdef AUTO_REPEAT_EN
    logic hold_clear;

    assign hold_clear = conflict | (state != ST_EDIT) | (state_next != state);

    btn_pulse #(.HOLD_DLY(HOLD_DLY), .REP_DIV(REP_DIV), .CW(CW)) u_up (
        .clk_1Hz (clk_1Hz),
        .rst     (rst),
        .btn     (btn_up),
        .clear   (hold_clear),
        .pulse   (up_pulse)
    );

    btn_pulse #(.HOLD_DLY(HOLD_DLY), .REP_DIV(REP_DIV), .CW(CW)) u_down (
        .clk_1Hz (clk_1Hz),
        .rst     (rst),
        .btn     (btn_down),
        .clear   (hold_clear),
        .pulse   (down_pulse)
    );
`else
    btn_pulse u_up (
        .clk_1Hz (clk_1Hz),
        .rst     (rst),
        .btn     (btn_up),
        .pulse   (up_pulse)
    );

    btn_pulse u_down (
        .clk_1Hz (clk_1Hz),
        .rst     (rst),
        .btn     (btn_down),
        .pulse   (down_pulse)
    );
`endif

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            select_item <= SEL_NONE;
            up          <= 1'b0;
            down        <= 1'b0;
            idle_cnt    <= '0;
            mode_q      <= 1'b0;
        end else begin
            state       <= state_next;
            select_item <= sel_next;
            up          <= up_next;
            down        <= down_next;
            idle_cnt    <= idle_next;
            mode_q      <= btn_mode;
        end
    end

    // Priority in EDIT: mode advance, then up/down activity, then idle timeout.
    always_comb begin
        state_next = state;
        sel_next   = select_item;
        up_next    = 1'b0;
        down_next  = 1'b0;
        idle_next  = idle_cnt;
        case (state)
            ST_RUN: begin
                idle_next = '0;
                if (mode_rise) begin
                    state_next = ST_EDIT;
                    sel_next   = SEL_SEC;
                end
            end
            ST_EDIT: begin
                if (mode_rise) begin
                    idle_next = '0;
                    sel_next  = next_item(select_item);
                    if (select_item == SEL_YEAR) begin
                        state_next = ST_RUN;
                    end
                end else if (up_pulse || down_pulse) begin
                    idle_next = '0;
                    up_next   = up_pulse & ~conflict;
                    down_next = down_pulse & ~conflict;
                end else if (idle_cnt == CW'(TIMEOUT - 1)) begin
                    state_next = ST_RUN;
                    sel_next   = SEL_NONE;
                    idle_next  = '0;
                end else begin
                    idle_next = idle_cnt + 1'b1;
                end
            end
        endcase
    end

endmodule
